survivor_mem: RTL and testbench

SURVIVOR_MEM -- requirements
Module: survivor_mem

---
 rtl/survivor_mem_pkg.sv | 42 ++++
 rtl/survivor_mem_array.sv | 39 +++
 rtl/survivor_mem.sv | 136 +++++++++++++
 tb/tb_survivor_mem.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/survivor_mem_pkg.sv
// ---------------------------------------------------------------------------
// survivor_mem_pkg
// Shared definitions for the Viterbi survivor (traceback) memory.
//   - Trellis sizing macros (`MAX_STATE_NUM, `MAX_STATE_REG_NUM,
//     `MAX_OUTPUT_BIT_NUM, `DECODE_BIT_NUM), defaulted here if the build
//     does not supply them.
//   - TD_DEPTH: number of trellis stages held (one entry per stage).
//   - LEVEL_W / ADDR_W: entry-count and memory-address widths.
//   - smem_state_e: FILL / DRAIN controller states.
// Optional feature macro used by survivor_mem: SMEM_ERR_EN.
// ---------------------------------------------------------------------------
`ifndef MAX_STATE_NUM
`define MAX_STATE_NUM 4
`endif
`ifndef MAX_STATE_REG_NUM
`define MAX_STATE_REG_NUM 2
`endif
`ifndef MAX_OUTPUT_BIT_NUM
`define MAX_OUTPUT_BIT_NUM 8
`endif
`ifndef DECODE_BIT_NUM
`define DECODE_BIT_NUM 1
`endif

package survivor_mem_pkg;

    localparam int ST_NUM   = `MAX_STATE_NUM;
    localparam int ST_W     = `MAX_STATE_REG_NUM;
    localparam int ENTRY_W  = ST_NUM * ST_W;
    localparam int TD_DEPTH = `MAX_OUTPUT_BIT_NUM / `DECODE_BIT_NUM;
    localparam int LEVEL_W  = $clog2(TD_DEPTH + 1);
    // Keep at least one address bit so a single-entry stack still elaborates.
    localparam int ADDR_W   = (TD_DEPTH > 1) ? $clog2(TD_DEPTH) : 1;

    localparam logic [LEVEL_W-1:0] LEVEL_FULL = LEVEL_W'(TD_DEPTH);

    typedef enum logic {
        FILL  = 1'b0,
        DRAIN = 1'b1
    } smem_state_e;

endpackage

// File: rtl/survivor_mem_array.sv
// ---------------------------------------------------------------------------
// smem_array
// Survivor storage: one entry per trellis stage. Synchronous write,
// asynchronous (combinational) read, no reset -- contents persist across
// reset and stale entries are masked by the owner's empty flag.
// Ports:
//   clk      : clock
//   i_we     : write enable
//   i_waddr  : write address
//   i_wdata  : write data (one full predecessor-state array)
//   i_raddr  : read address
//   o_rdata  : read data, valid in the same cycle as i_raddr
// ---------------------------------------------------------------------------
module smem_array
    import survivor_mem_pkg::*;
#(
    parameter int DEPTH  = TD_DEPTH,
    parameter int AW     = ADDR_W,
    parameter int DATA_W = ENTRY_W
) (
    input  logic              clk,
    input  logic              i_we,
    input  logic [AW-1:0]     i_waddr,
    input  logic [DATA_W-1:0] i_wdata,
    input  logic [AW-1:0]     i_raddr,
    output logic [DATA_W-1:0] o_rdata
);

    logic [DATA_W-1:0] r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/survivor_mem.sv
// ---------------------------------------------------------------------------
// survivor_mem
// LIFO of survivor predecessor arrays between the ACS stage (writer) and the
// traceback stage (reader). FILL accepts one stage per en_s until full, then
// DRAIN hands entries back newest-first on en_t until empty.
// Ports:
//   clk          : clock, rising edge
//   rst          : synchronous reset, active low
//   en_s         : push request (honoured only in FILL)
//   i_prv_st     : predecessor state per trellis state, current stage
//   en_t         : pop request (honoured only in DRAIN)
//   o_bck_prv_st : top-of-stack entry, zero when empty, zero latency
//   o_td_empty   : level == 0
//   o_td_full    : level == TD_DEPTH
//   o_fill_done  : one-cycle pulse in the first DRAIN cycle
//   o_level      : current entry count
//   o_td_err     : sticky misuse flag (only when SMEM_ERR_EN is defined)
// Build macro: SMEM_ERR_EN adds o_td_err.
// ---------------------------------------------------------------------------
module survivor_mem
    import survivor_mem_pkg::*;
(
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            en_s,
    input  logic [ST_NUM-1:0][ST_W-1:0]     i_prv_st,
    input  logic                            en_t,
    output logic [ST_NUM-1:0][ST_W-1:0]     o_bck_prv_st,
    output logic                            o_td_empty,
    output logic                            o_td_full,
    output logic                            o_fill_done,
    output logic [LEVEL_W-1:0]              o_level
`ifdef SMEM_ERR_EN
    ,
    output logic                            o_td_err
`endif
);

    smem_state_e        r_state;
    smem_state_e        w_state_next;
    logic [LEVEL_W-1:0] r_level;
    logic [LEVEL_W-1:0] w_level_next;
    logic               r_fill_done;
    logic               w_push;
    logic               w_empty;
    logic               w_full;
    logic [ADDR_W-1:0]  w_rd_addr;
    logic [ENTRY_W-1:0] w_rd_data;

    assign w_empty = (r_level == '0);
    assign w_full  = (r_level == LEVEL_FULL);

    always_comb begin
        w_state_next = r_state;
        w_level_next = r_level;
        w_push       = 1'b0;
        case (r_state)
            FILL: begin
                if (en_s && !w_full) begin
                    w_push       = 1'b1;
                    w_level_next = r_level + 1'b1;
                    if (w_level_next == LEVEL_FULL) begin
                        w_state_next = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (en_t && !w_empty) begin
                    w_level_next = r_level - 1'b1;
                    if (w_level_next == '0) begin
                        w_state_next = FILL;
                    end
                end
            end
            default: begin
                w_state_next = FILL;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state     <= FILL;
            r_level     <= '0;
            r_fill_done <= 1'b0;
        end else begin
            r_state     <= w_state_next;
            r_level     <= w_level_next;
            // Pulse marks the cycle right after the FILL->DRAIN edge.
            r_fill_done <= (r_state == FILL) && (w_state_next == DRAIN);
        end
    end

`ifdef SMEM_ERR_EN
    logic r_td_err;
    logic w_err_evt;

    assign w_err_evt = (en_s && ((r_state == DRAIN) || w_full)) ||
                       (en_t && ((r_state == FILL)  || w_empty));

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_td_err <= 1'b0;
        end else if (w_err_evt) begin
            r_td_err <= 1'b1;
        end
    end

    assign o_td_err = r_td_err;
`endif

    // Top of stack lives at level-1; the wrap at level 0 is harmless because
    // the output is masked by empty.
    assign w_rd_addr = ADDR_W'(r_level - 1'b1);

    smem_array u_smem_array (
        .clk     (clk),
        .i_we    (w_push),
        .i_waddr (r_level[ADDR_W-1:0]),
        .i_wdata (i_prv_st),
        .i_raddr (w_rd_addr),
        .o_rdata (w_rd_data)
    );

    generate
        for (genvar gi = 0; gi < ST_NUM; gi++) begin : g_out
            assign o_bck_prv_st[gi] = w_empty ? '0 : w_rd_data[gi*ST_W +: ST_W];
        end
    endgenerate

    assign o_td_empty  = w_empty;
    assign o_td_full   = w_full;
    assign o_fill_done = r_fill_done;
    assign o_level     = r_level;

endmodule

// File: tb/tb_survivor_mem.sv
// ---------------------------------------------------------------------------
// tb_survivor_mem
// Self-checking bench for survivor_mem: a constant vector table for the
// basic fill/drain walk, hand-written corner sequences, and a randomized run
// compared against a queue-based stack model.
// ---------------------------------------------------------------------------
module tb_survivor_mem;
    import survivor_mem_pkg::*;

    typedef logic [ST_NUM-1:0][ST_W-1:0] arr_t;

    logic               clk = 1'b0;
    logic               rst;
    logic               en_s;
    logic               en_t;
    arr_t               prv;
    arr_t               bck;
    logic               empty;
    logic               full;
    logic               fd;
    logic [LEVEL_W-1:0] level;
`ifdef SMEM_ERR_EN
    logic               err;
`endif

    always #5 clk = ~clk;

    survivor_mem dut (
        .clk          (clk),
        .rst          (rst),
        .en_s         (en_s),
        .i_prv_st     (prv),
        .en_t         (en_t),
        .o_bck_prv_st (bck),
        .o_td_empty   (empty),
        .o_td_full    (full),
        .o_fill_done  (fd),
        .o_level      (level)
`ifdef SMEM_ERR_EN
        ,
        .o_td_err     (err)
`endif
    );

    int checks   = 0;
    int failures = 0;

    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic arr_t mk(int k);
        arr_t v;
        for (int i = 0; i < ST_NUM; i++) v[i] = ST_W'(k);
        return v;
    endfunction

    function automatic arr_t rnd_arr();
        logic [31:0] r;
        r = $urandom;
        return r[ENTRY_W-1:0];
    endfunction

    // ---------------- behavioural model: a queue used as a stack ----------
    arr_t m_stack[$];
    bit   m_drain;
    bit   m_fd;
`ifdef SMEM_ERR_EN
    bit   m_err;
`endif

    function automatic void model_step(bit r, bit s, bit t, arr_t d);
`ifdef SMEM_ERR_EN
        if (!r) m_err = 0;
        else if ((s && (m_drain || m_stack.size() == TD_DEPTH)) ||
                 (t && (!m_drain || m_stack.size() == 0))) m_err = 1;
`endif
        if (!r) begin
            m_stack.delete();
            m_drain = 0;
            m_fd    = 0;
            return;
        end
        m_fd = 0;
        if (!m_drain) begin
            if (s && m_stack.size() < TD_DEPTH) begin
                m_stack.push_back(d);
                if (m_stack.size() == TD_DEPTH) begin
                    m_drain = 1;
                    m_fd    = 1;
                end
            end
        end else begin
            if (t && m_stack.size() > 0) begin
                void'(m_stack.pop_back());
                if (m_stack.size() == 0) m_drain = 0;
            end
        end
    endfunction

    // Drive one cycle, advance the model, compare every output after the edge.
    task automatic step(string tag, bit r, bit s, bit t, arr_t d);
        arr_t exp_bck;
        rst = r; en_s = s; en_t = t; prv = d;
        model_step(r, s, t, d);
        @(posedge clk); #1;
        exp_bck = (m_stack.size() > 0) ? m_stack[$] : '0;
        $display("%s rst=%0b en_s=%0b en_t=%0b din=%0h level=%0d top=%0h fd=%0b",
                 tag, r, s, t, d, level, bck, fd);
        chk({tag, "_level"}, level, m_stack.size());
        chk({tag, "_empty"}, empty, m_stack.size() == 0);
        chk({tag, "_full"},  full,  m_stack.size() == TD_DEPTH);
        chk({tag, "_fd"},    fd,    m_fd);
        chk({tag, "_top"},   bck,   exp_bck);
`ifdef SMEM_ERR_EN
        chk({tag, "_err"},   err,   m_err);
`endif
    endtask

    // ---------------- constant vector table ----------------
    typedef struct {
        bit   r;
        bit   s;
        bit   t;
        arr_t d;
        int   lvl;
        bit   full;
        bit   empty;
        bit   fd;
        arr_t bck;
    } vec_t;

    localparam int NV = 20;
    vec_t tbl[NV];

    arr_t saved[TD_DEPTH];
    int   seq32[10] = '{1, 2, 3, 4, 5, 6, 7, 8, 7, 6};

    initial begin
        rst = 1'b0; en_s = 1'b0; en_t = 1'b0; prv = '0;

        tbl[0] = '{1'b0, 1'b0, 1'b0, '0, 0, 1'b0, 1'b1, 1'b0, '0};
        for (int k = 0; k < 8; k++)
            tbl[1+k] = '{1'b1, 1'b1, 1'b0, mk(k), k + 1, (k == 7), 1'b0, (k == 7), mk(k)};
        // Push attempt while full / in DRAIN: nothing changes.
        tbl[9] = '{1'b1, 1'b1, 1'b0, mk(1), 8, 1'b1, 1'b0, 1'b0, mk(7)};
        for (int j = 1; j <= 8; j++)
            tbl[9+j] = '{1'b1, 1'b0, 1'b1, '0, 8 - j, 1'b0, (j == 8), 1'b0,
                         (j == 8) ? '0 : mk(7 - j)};
        // Back in FILL: push accepted, then en_t ignored.
        tbl[18] = '{1'b1, 1'b1, 1'b0, mk(2), 1, 1'b0, 1'b0, 1'b0, mk(2)};
        tbl[19] = '{1'b1, 1'b0, 1'b1, '0,    1, 1'b0, 1'b0, 1'b0, mk(2)};

        for (int i = 0; i < NV; i++) begin
            rst = tbl[i].r; en_s = tbl[i].s; en_t = tbl[i].t; prv = tbl[i].d;
            @(posedge clk); #1;
            $display("vec%0d rst=%0b en_s=%0b en_t=%0b level=%0d top=%0h fd=%0b",
                     i, tbl[i].r, tbl[i].s, tbl[i].t, level, bck, fd);
            chk($sformatf("vec%0d_level", i), level, tbl[i].lvl);
            chk($sformatf("vec%0d_full", i),  full,  tbl[i].full);
            chk($sformatf("vec%0d_empty", i), empty, tbl[i].empty);
            chk($sformatf("vec%0d_fd", i),    fd,    tbl[i].fd);
            chk($sformatf("vec%0d_top", i),   bck,   tbl[i].bck);
        end
`ifdef SMEM_ERR_EN
        chk("vec_err_sticky", err, 1'b1);
`endif

        // ---- 9th push while full, then drain with distinct data ----
        step("full_rst", 0, 0, 0, '0);
        for (int k = 0; k < TD_DEPTH; k++) begin
            saved[k] = rnd_arr();
            step("full_push", 1, 1, 0, saved[k]);
        end
        step("full_9th", 1, 1, 0, ~saved[0]);
        chk("full_9th_level", level, 8);
        chk("full_9th_top", bck, saved[TD_DEPTH-1]);
`ifdef SMEM_ERR_EN
        chk("full_9th_err", err, 1'b1);
`endif
        for (int k = TD_DEPTH - 1; k >= 0; k--) begin
            chk("full_pop_pre", bck, saved[k]);
            step("full_pop", 1, 0, 1, '0);
        end

        // ---- reset in the middle of DRAIN ----
        step("mid_rst0", 0, 0, 0, '0);
        for (int k = 0; k < TD_DEPTH; k++) step("mid_push", 1, 1, 0, rnd_arr());
        for (int k = 0; k < 3; k++) step("mid_pop", 1, 0, 1, '0);
        chk("mid_level5", level, 5);
        step("mid_rst", 0, 1, 1, rnd_arr());
        chk("mid_rst_level", level, 0);
        chk("mid_rst_empty", empty, 1'b1);
        chk("mid_rst_top", bck, '0);
        saved[0] = rnd_arr() | mk(1);
        step("mid_after", 1, 1, 0, saved[0]);
        chk("mid_after_top", bck, saved[0]);

        // ---- en_s and en_t held together from empty ----
        step("both_rst", 0, 0, 0, '0);
        for (int c = 0; c < 10; c++) begin
            step("both", 1, 1, 1, rnd_arr());
            chk($sformatf("both%0d_level", c), level, seq32[c]);
            chk($sformatf("both%0d_fd", c), fd, (c == 7));
        end

        // ---- en_t during FILL at level 3 ----
        step("ft_rst", 0, 0, 0, '0);
        for (int k = 0; k < 3; k++) begin
            saved[k] = rnd_arr();
            step("ft_push", 1, 1, 0, saved[k]);
        end
        step("ft_pop", 1, 0, 1, '0);
        chk("ft_level", level, 3);
        chk("ft_top", bck, saved[2]);

        // ---- randomized run against the model ----
        step("rnd_rst", 0, 0, 0, '0);
        for (int n = 0; n < 400; n++) begin
            step("rnd", ($urandom_range(0, 59) != 0), ($urandom_range(0, 9) < 7),
                 ($urandom_range(0, 1) == 1), rnd_arr());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
